// File: rtl/deinterl_bank_sched_if.sv
// Scheduler handshake bundle: write-end pulse and downstream ready in, bank/read sequencing out.
// The master side is the write-side counter plus the RAM/ROM read consumer; the slave side is the scheduler.
interface deinterl_bank_sched_if #(
  parameter int CNT_W = 13
) ();
  logic             iwr_end;
  logic             idst_rdy;
  logic             owr_bank;
  logic             ord_bank;
  logic [CNT_W-1:0] ord_cnt;
  logic             ord_en;
  logic             osop;
  logic             oeop;
  logic             ogap;
  logic             oerr;
  logic [7:0]       odrop_cnt;

  modport master (
    output iwr_end, idst_rdy,
    input  owr_bank, ord_bank, ord_cnt, ord_en, osop, oeop, ogap, oerr, odrop_cnt
  );

  modport slave (
    input  iwr_end, idst_rdy,
    output owr_bank, ord_bank, ord_cnt, ord_en, osop, oeop, ogap, oerr, odrop_cnt
  );
endinterface

// File: rtl/deinterl_bank_sched.sv
// Ping-pong bank scheduler for the deinterleaver RAM: write-bank select, two-half permuted read with a gap.
// Read strobe is combinational on idst_rdy (0 cycles); a full bank starts reading 1 cycle after it is seen.
module deinterl_bank_sched #(
  parameter int PACK_LEN = 4608,
  parameter int HALF_LEN = 2304,
  parameter int GAP_LEN  = 1000,
  parameter int CNT_W    = 13
) (
  input  logic                  iclk,
  input  logic                  irst,
  deinterl_bank_sched_if.slave  bus
);

  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CNT_W-1:0] HALF_FIRST = CNT_W'(HALF_LEN);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_LEN - 1);
  localparam logic [CNT_W-1:0] PACK_LAST  = CNT_W'(PACK_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_H1 = 2'd1,
    GAP   = 2'd2,
    RD_H2 = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rd_bank_q, rd_bank_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       full_rel;
  logic             err_q, err_d;
  logic [7:0]       drop_q, drop_d;

  logic             rd_active;
  logic             rd_en;
  logic             release_bank;
  logic             overrun;

  assign rd_active = (state_q == RD_H1) || (state_q == RD_H2);
  assign rd_en     = rd_active && bus.idst_rdy;

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      err_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  // Read sequencer: the gap counter runs on wall-clock cycles, only the halves follow idst_rdy.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    rd_bank_d    = rd_bank_q;
    release_bank = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = RD_H1;
          cnt_d   = '0;
        end
      end
      RD_H1: begin
        if (rd_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_LAST) begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = RD_H2;
          cnt_d   = HALF_FIRST;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RD_H2: begin
        if (rd_en) begin
          if (cnt_q == PACK_LAST) begin
            release_bank = 1'b1;
            rd_bank_d    = ~rd_bank_q;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release is applied before the write so a same-cycle freed bank is never counted as an overrun.
  // The write pointer then moves to the other bank whenever its own bank is full and the other is free,
  // which also covers a parked pointer catching up on a later release.
  always_comb begin
    full_rel = full_q;
    if (release_bank) begin
      full_rel[rd_bank_q] = 1'b0;
    end
    overrun = bus.iwr_end && full_rel[wr_bank_q];
    full_d  = full_rel;
    if (bus.iwr_end) begin
      full_d[wr_bank_q] = 1'b1;
    end
    wr_bank_d = wr_bank_q;
    if (full_d[wr_bank_q] && !full_d[~wr_bank_q]) begin
      wr_bank_d = ~wr_bank_q;
    end
    err_d  = overrun;
    drop_d = drop_q;
    if (overrun && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  assign bus.owr_bank  = wr_bank_q;
  assign bus.ord_bank  = rd_bank_q;
  assign bus.ord_cnt   = cnt_q;
  assign bus.ord_en    = rd_en;
  assign bus.osop      = rd_en && ((cnt_q == '0) || (cnt_q == HALF_FIRST));
  assign bus.oeop      = rd_en && ((cnt_q == HALF_LAST) || (cnt_q == PACK_LAST));
  assign bus.ogap      = (state_q == GAP);
  assign bus.oerr      = err_q;
  assign bus.odrop_cnt = drop_q;

endmodule
